// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, shift-unit FSM state encoding and an opcode legality helper.
package alu_pkg;

    localparam logic [4:0] ROR_OP  = 5'b00111;
    localparam logic [4:0] ROL_OP  = 5'b01000;
    localparam logic [4:0] SHR_OP  = 5'b01001;
    localparam logic [4:0] SHRA_OP = 5'b01010;
    localparam logic [4:0] SHL_OP  = 5'b01011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == ROR_OP) || (op == ROL_OP) || (op == SHR_OP) ||
               (op == SHRA_OP) || (op == SHL_OP);
    endfunction

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational op-selected shift by a fixed distance DIST (1 for the iterative path,
// a power of two for each barrel stage). Unknown opcodes pass the data through.
module shift_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            SHR_OP:  data_o = data_i >> DIST;
            SHRA_OP: data_o = $signed(data_i) >>> DIST;
            SHL_OP:  data_o = data_i << DIST;
            ROR_OP:  data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
            ROL_OP:  data_o = (data_i << DIST) | (data_i >> (WIDTH - DIST));
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake.
// Define SEQ_SHIFT_BARREL_EN to replace the 1-bit/cycle loop with a single-cycle barrel shifter.
module seq_shift_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [4:0]       op_code,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op
);

    localparam int unsigned AMT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] step_out;
    logic [AMT_W-1:0] amt;
    logic             unused_amount_hi;

    // Shift count is taken modulo WIDTH; the upper amount bits are ignored.
    assign amt              = amount[AMT_W-1:0];
    assign unused_amount_hi = ^amount[WIDTH-1:AMT_W];

    shift_step #(
        .WIDTH (WIDTH),
        .DIST  (1)
    ) u_step (
        .op_i   (op_q),
        .data_i (work_q),
        .data_o (step_out)
    );

`ifdef SEQ_SHIFT_BARREL_EN
    logic [WIDTH-1:0] barrel_out;

    // Stage s shifts by 2**s when amount bit s is set; stages chain LSB first.
    for (genvar s = 0; s < AMT_W; s++) begin : g_barrel
        logic [WIDTH-1:0] stage_in;
        logic [WIDTH-1:0] shifted;
        logic [WIDTH-1:0] stage_out;
        if (s == 0) begin : g_first
            assign stage_in = operand;
        end else begin : g_next
            assign stage_in = g_barrel[s-1].stage_out;
        end
        shift_step #(
            .WIDTH (WIDTH),
            .DIST  (1 << s)
        ) u_stage (
            .op_i   (op_code),
            .data_i (stage_in),
            .data_o (shifted)
        );
        assign stage_out = amt[s] ? shifted : stage_in;
    end

    assign barrel_out = g_barrel[AMT_W-1].stage_out;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        work_d    = work_q;
        result_d  = result_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op_code;
                    work_d    = operand;
                    count_d   = amt;
                    illegal_d = 1'b0;
                    if (!is_shift_op(op_code)) begin
                        illegal_d = 1'b1;
                        result_d  = operand;
                        state_d   = S_DONE;
                    end else if (amt == '0) begin
                        result_d = operand;
                        state_d  = S_DONE;
                    end else begin
`ifdef SEQ_SHIFT_BARREL_EN
                        work_d   = barrel_out;
                        result_d = barrel_out;
                        count_d  = '0;
                        state_d  = S_DONE;
`else
                        state_d  = S_SHIFT;
`endif
                    end
                end
            end
            S_SHIFT: begin
                work_d  = step_out;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    result_d = step_out;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            work_q    <= '0;
            result_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            result_q  <= result_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign result     = result_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: directed cases plus randomized requests against a whole-shift reference model.
module tb_seq_shift_unit;

    localparam int unsigned W = 32;

    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;

`ifdef SEQ_SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic [4:0]   op_code;
    logic [W-1:0] operand;
    logic [W-1:0] amount;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         illegal_op;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op_code    (op_code),
        .operand    (operand),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .illegal_op (illegal_op)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int unsigned  done_cyc;
        int unsigned  busy_n;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-shift reference: returns {illegal, result}.
    function automatic logic [W:0] ref_model(input logic [4:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] amt);
        int unsigned         n;
        logic signed [W-1:0] sx;
        n  = amt % W;
        sx = x;
        case (op)
            OP_SHR:  return {1'b0, x >> n};
            OP_SHRA: return {1'b0, sx >>> n};
            OP_SHL:  return {1'b0, x << n};
            OP_ROR:  return (n == 0) ? {1'b0, x} : {1'b0, (x >> n) | (x << (W - n))};
            OP_ROL:  return (n == 0) ? {1'b0, x} : {1'b0, (x << n) | (x >> (W - n))};
            default: return {1'b1, x};
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (busy) busy_seen++;
        if (done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %h with no pending request (cycle %0d)", result, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.res);
                chk("illegal_op", {{(W-1){1'b0}}, illegal_op}, {{(W-1){1'b0}}, mon_e.ill});
                chk("latency", cyc, mon_e.done_cyc);
                chk("busy_cycles", busy_seen, mon_e.busy_n);
            end
            busy_seen = 0;
        end
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] amt,
                         input logic [W-1:0] exp_res, input logic exp_ill, input bit noise);
        exp_t        e;
        int unsigned n;
        bit          got;
        n = (exp_ill || BARREL) ? 0 : amt % W;
        @(negedge clk);
        e.res      = exp_res;
        e.ill      = exp_ill;
        e.done_cyc = cyc + 1 + n;
        e.busy_n   = n;
        sbq.push_back(e);
        op_code = op;
        operand = x;
        amount  = amt;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (noise && busy && $urandom_range(0, 2) == 0) begin
                start   = 1'b1;
                operand = $urandom;
                amount  = $urandom;
                op_code = OP_SHL;
            end
            @(negedge clk);
            start = 1'b0;
        end
        if (!got) begin
            chk("done_timeout", 0, 1);
            if (sbq.size() != 0) void'(sbq.pop_front());
        end else begin
            @(negedge clk);
            chk("done_pulse_width", {{(W-1){1'b0}}, done}, '0);
            chk("result_hold", result, exp_res);
        end
    endtask

    logic [4:0]   legal_ops [5];
    logic [4:0]   rop;
    logic [W-1:0] rx;
    logic [W-1:0] ramt;
    logic [W:0]   rexp;

    initial begin
        legal_ops[0] = OP_ROR;
        legal_ops[1] = OP_ROL;
        legal_ops[2] = OP_SHR;
        legal_ops[3] = OP_SHRA;
        legal_ops[4] = OP_SHL;

        clr     = 1'b1;
        start   = 1'b0;
        op_code = '0;
        operand = '0;
        amount  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("reset_done", {{(W-1){1'b0}}, done}, '0);
        chk("reset_result", result, '0);
        chk("reset_illegal", {{(W-1){1'b0}}, illegal_op}, '0);
        clr = 1'b0;

        issue(OP_SHRA, 32'h8000_0022, 32'd4,  32'hF800_0002, 1'b0, 1'b0);
        issue(OP_SHR,  32'h0000_0022, 32'd4,  32'h0000_0002, 1'b0, 1'b0);
        issue(OP_ROL,  32'h8000_0001, 32'd1,  32'h0000_0003, 1'b0, 1'b0);
        issue(OP_ROR,  32'h0000_0001, 32'd33, 32'h8000_0000, 1'b0, 1'b0);
        issue(OP_SHL,  32'h0000_0028, 32'd0,  32'h0000_0028, 1'b0, 1'b0);
        issue(5'b00011, 32'hDEAD_BEEF, 32'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
        issue(OP_SHL,  32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        issue(OP_SHR,  32'hA5A5_A5A5, 32'd20, 32'h0000_0A5A, 1'b0, 1'b1);

`ifndef SEQ_SHIFT_BARREL_EN
        // clr two cycles into a 10-step shift: request is dropped, no done follows.
        @(negedge clk);
        op_code = OP_SHR;
        operand = $urandom;
        amount  = 32'd10;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("midclr_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("midclr_done", {{(W-1){1'b0}}, done}, '0);
        chk("midclr_result", result, '0);
        repeat (14) @(negedge clk);
        busy_seen = 0;
        issue(OP_ROL, 32'h1234_5678, 32'd4, 32'h2345_6781, 1'b0, 1'b0);
`endif

        // start and clr together: clr wins.
        @(negedge clk);
        op_code = OP_SHL;
        operand = 32'h0000_1234;
        amount  = 32'd0;
        start   = 1'b1;
        clr     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        chk("startclr_done", {{(W-1){1'b0}}, done}, '0);
        chk("startclr_busy", {{(W-1){1'b0}}, busy}, '0);
        chk("startclr_result", result, '0);
        repeat (3) @(negedge clk);

        repeat (150) begin
            if ($urandom_range(0, 9) == 0) rop = 5'b10000 | 5'($urandom_range(0, 15));
            else                           rop = legal_ops[$urandom_range(0, 4)];
            rx   = $urandom;
            ramt = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            rexp = ref_model(rop, rx, ramt);
            issue(rop, rx, ramt, rexp[W-1:0], rexp[W], 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", W'(sbq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
